// File: rtl/vppm_pwm_capture_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vppm_pwm_capture_if
//  Brief    : Result bus of the PWM/VPPM capture block (duty, period, high
//             time, strobe and status flags).
//  Revision : 1.0 - initial release
// ============================================================================
interface vppm_pwm_capture_if #(
   parameter int CNT_W = 26,
   parameter int OUT_W = 12
);
   logic [OUT_W-1:0] duty_out;
   logic [CNT_W-1:0] period_out;
   logic [CNT_W-1:0] high_out;
   logic             duty_valid;
   logic             timeout;
   logic             overrun;

   // Capture block drives the results
   modport master (
      output duty_out, period_out, high_out, duty_valid, timeout, overrun
   );

   // Demodulation / reconstruction logic consumes them
   modport slave (
      input duty_out, period_out, high_out, duty_valid, timeout, overrun
   );
endinterface
`default_nettype wire

// File: rtl/vppm_pwm_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vppm_pwm_capture
//  Brief    : Measures an incoming PWM/VPPM pulse train. Per period it
//             recovers the high time, the period and a duty word
//             floor(high * 2^OUT_W / period) using a sequential restoring
//             divider that runs alongside the free-running counters.
//  Revision : 1.0 - initial release
// ============================================================================
module vppm_pwm_capture #(
   parameter int               CNT_W      = 26,
   parameter int               OUT_W      = 12,
   parameter logic [CNT_W-1:0] MAX_PERIOD = 26'd5_000_000
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               pwm_in,
   vppm_pwm_capture_if.master      bus
);

   localparam int               REM_W     = CNT_W + OUT_W + 1;
   localparam int               STEP_W    = $clog2(OUT_W);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(OUT_W - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      DIVIDE  = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_sync1;
   logic              r_s;
   logic              r_s_d;
   logic [CNT_W-1:0]  r_period_cnt;
   logic [CNT_W-1:0]  r_high_cnt;
   logic [CNT_W-1:0]  r_cap_period;
   logic [CNT_W-1:0]  r_cap_high;
   logic [REM_W-1:0]  r_rem;
   logic [OUT_W-2:0]  r_quo;
   logic              r_ovf;
   logic [STEP_W-1:0] r_step;

   logic              w_rise;
   logic              w_timeout;
   logic              w_last;
   logic              w_ge;
   logic              w_ovf_final;
   logic [REM_W-1:0]  w_rem_sh;
   logic [REM_W-1:0]  w_div;
   logic [REM_W-1:0]  w_rem_nx;
   logic [OUT_W-1:0]  w_quo_nx;
   logic [CNT_W-1:0]  w_period_inc;
   logic [CNT_W-1:0]  w_high_inc;

   // Edge detect, timeout detect and one restoring-division step
   always_comb begin
      w_rise       = r_s & ~r_s_d;
      // An edge in the same cycle as the timeout is treated as a capture
      w_timeout    = (r_state == MEASURE) && (r_period_cnt >= MAX_PERIOD) && !w_rise;
      w_last       = (r_step == LAST_STEP);
      w_rem_sh     = {r_rem[REM_W-2:0], 1'b0};
      w_div        = {{(OUT_W+1){1'b0}}, r_cap_period};
      w_ge         = (w_rem_sh >= w_div);
      w_rem_nx     = w_ge ? (w_rem_sh - w_div) : w_rem_sh;
      w_quo_nx     = {r_quo, w_ge};
      // A remainder bit shifted out also means the quotient cannot be trusted
      w_ovf_final  = r_ovf | r_rem[REM_W-1];
      w_period_inc = (r_period_cnt >= MAX_PERIOD) ? MAX_PERIOD : r_period_cnt + CNT_W'(1);
      w_high_inc   = (r_high_cnt >= MAX_PERIOD) ? MAX_PERIOD : r_high_cnt + CNT_W'(1);
   end

   // Two-flop synchronizer plus delay stage for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_s     <= 1'b0;
         r_s_d   <= 1'b0;
      end else begin
         r_sync1 <= pwm_in;
         r_s     <= r_sync1;
         r_s_d   <= r_s;
      end
   end

   // Period/high counters: reload on every edge, saturate, idle at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_period_cnt <= '0;
         r_high_cnt   <= '0;
      end else if (w_timeout) begin
         r_period_cnt <= '0;
         r_high_cnt   <= '0;
      end else if (w_rise) begin
         r_period_cnt <= CNT_W'(1);
         r_high_cnt   <= CNT_W'(1);
      end else if (r_state == IDLE) begin
         r_period_cnt <= '0;
         r_high_cnt   <= '0;
      end else begin
         r_period_cnt <= w_period_inc;
         if (r_s) begin
            r_high_cnt <= w_high_inc;
         end
      end
   end

   // Control FSM with capture latch, divider iteration and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_cap_period   <= '0;
         r_cap_high     <= '0;
         r_rem          <= '0;
         r_quo          <= '0;
         r_ovf          <= 1'b0;
         r_step         <= '0;
         bus.duty_out   <= '0;
         bus.period_out <= '0;
         bus.high_out   <= '0;
         bus.duty_valid <= 1'b0;
         bus.timeout    <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         bus.duty_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_rise) begin
                  r_state <= MEASURE;
               end
            end
            MEASURE: begin
               if (w_rise) begin
                  r_cap_period <= r_period_cnt;
                  r_cap_high   <= r_high_cnt;
                  r_rem        <= REM_W'(r_high_cnt);
                  r_quo        <= '0;
                  r_ovf        <= (r_high_cnt >= r_period_cnt);
                  r_step       <= '0;
                  r_state      <= DIVIDE;
               end else if (w_timeout) begin
                  bus.duty_out   <= {OUT_W{r_s}};
                  bus.period_out <= '0;
                  bus.high_out   <= '0;
                  bus.duty_valid <= 1'b1;
                  bus.timeout    <= 1'b1;
                  r_state        <= IDLE;
               end
            end
            DIVIDE: begin
               r_rem  <= w_rem_nx;
               r_quo  <= w_quo_nx[OUT_W-2:0];
               r_ovf  <= w_ovf_final;
               r_step <= r_step + STEP_W'(1);
               if (w_last) begin
                  bus.duty_out   <= w_ovf_final ? {OUT_W{1'b1}} : w_quo_nx;
                  bus.period_out <= r_cap_period;
                  bus.high_out   <= r_cap_high;
                  bus.duty_valid <= 1'b1;
                  bus.timeout    <= 1'b0;
                  r_state        <= MEASURE;
                  // Edge arriving as the division finishes chains straight in
                  if (w_rise) begin
                     r_cap_period <= r_period_cnt;
                     r_cap_high   <= r_high_cnt;
                     r_rem        <= REM_W'(r_high_cnt);
                     r_quo        <= '0;
                     r_ovf        <= (r_high_cnt >= r_period_cnt);
                     r_step       <= '0;
                     r_state      <= DIVIDE;
                  end
               end else if (w_rise) begin
                  bus.overrun <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
